// File: rtl/cv32e40s_lsu_write_buffer.sv
// cv32e40s_lsu_write_buffer
// Bus-side write buffer of the LSU. It holds up to DEPTH bufferable stores
// so they can retire before the bus grants them. Non-bufferable transfers
// pass straight through, and only while the buffer is empty, so bus order
// always matches upstream acceptance order.
// Optional build feature: define CV32E40S_WBUF_HWM_EN to add the hwm_o
// occupancy high-water-mark output.

package cv32e40s_wbuf_pkg;
  // OBI data request as seen between the response filter and the bus.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  memtype;   // [0] = bufferable, [1] = cacheable
    logic [2:0]  prot;
    logic        dbg;
  } obi_data_req_t;
endpackage

module cv32e40s_lsu_write_buffer
  import cv32e40s_wbuf_pkg::*;
#(
  parameter  int DEPTH     = 2,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  obi_data_req_t        trans_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output obi_data_req_t        trans_o,
  input  logic                 ready_i,
`ifdef CV32E40S_WBUF_HWM_EN
  output logic [CNT_WIDTH-1:0] hwm_o,
`endif
  output logic                 busy_o,
  output logic                 empty_o,
  output logic                 full_o
);

  // Pointer width stays at least one bit so DEPTH=1 still elaborates.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  obi_data_req_t        storage [DEPTH];
  logic [CNT_WIDTH-1:0] cnt;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;

  logic                 bufferable;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;

  assign bufferable = trans_i.we && trans_i.memtype[0];
  assign empty      = (cnt == '0);
  assign full       = (cnt == CNT_WIDTH'(DEPTH));

  // Output muxing and handshake decisions; the mode is implied by cnt.
  always_comb begin
    valid_o = 1'b1;
    trans_o = storage[rd_ptr];
    ready_o = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    if (empty) begin
      // Zero-latency bypass. A store that is not granted right away is
      // captured, and the same transfer is then presented from storage,
      // keeping the address phase stable.
      valid_o = valid_i;
      trans_o = trans_i;
      ready_o = ready_i || bufferable;
      push    = valid_i && !ready_i && bufferable;
    end else begin
      // Once anything is held, acceptance never depends on ready_i; a full
      // buffer refuses even if the head is granted this cycle.
      ready_o = !full && bufferable;
      push    = !full && valid_i && bufferable;
      pop     = ready_i;
    end
  end

  // Occupancy counter and read/write pointers with explicit wrap at DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push && !pop) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CNT_WIDTH'(1);
      end
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

  // Entry storage; an accepted store is written once and never modified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (push) begin
      storage[wr_ptr] <= trans_i;
    end
  end

`ifdef CV32E40S_WBUF_HWM_EN
  logic [CNT_WIDTH-1:0] hwm;

  // High-water mark: lags cnt by one cycle and saturates at DEPTH since cnt does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm <= '0;
    end else if (cnt > hwm) begin
      hwm <= cnt;
    end
  end

  assign hwm_o = hwm;
`endif

  assign busy_o  = !empty;
  assign empty_o = empty;
  assign full_o  = full;

endmodule

// File: doc/cv32e40s_lsu_write_buffer.md
Name: cv32e40s_lsu_write_buffer

Overview:
- Bus-side stage of the LSU, directly downstream of the LSU response filter's request output (the filter's valid_o/trans_o/ready_i); its output drives the OBI data interface.
- Holds up to DEPTH bufferable stores (trans_i.we=1 and trans_i.memtype[0]=1) so the core can retire them before the bus accepts them.
- Non-bufferable transfers pass straight through, but only when the buffer is empty, so bus order is preserved.
- Response handling is out of scope; the response filter owns it.

Parameters:
- DEPTH, 2, number of buffered store entries (>=1).
- CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width (derived, not overridable).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- valid_i  input  1  upstream request valid
- trans_i  input  obi_data_req_t  upstream request (addr, we, be, wdata, memtype, prot, ...)
- ready_o  output  1  upstream request accepted (taken into buffer or passed through)
- valid_o  output  1  bus request valid
- trans_o  output  obi_data_req_t  bus request
- ready_i  input  1  bus grant
- busy_o  output  1  buffer holds at least one entry
- empty_o  output  1  occupancy == 0
- full_o  output  1  occupancy == DEPTH

Behaviour:
- Reset: cnt=0, rd_ptr=0, wr_ptr=0, storage cleared to '0. After reset: valid_o=valid_i, ready_o per the rules below, busy_o=0, empty_o=1, full_o=0.
- bufferable_i = trans_i.we && trans_i.memtype[0].
- Modes (derived from cnt; no separate FSM register):
  - EMPTY (cnt==0):
    - valid_o=valid_i, trans_o=trans_i (combinational bypass, zero latency).
    - ready_o = ready_i || bufferable_i.
    - Bypass when valid_i && ready_i: the transfer goes to the bus and is not stored.
    - Enqueue when valid_i && !ready_i && bufferable_i: entry written at wr_ptr, cnt=1 next cycle. trans_o next cycle equals the same transfer, so the OBI address phase stays stable.
  - PARTIAL (0<cnt<DEPTH):
    - valid_o=1, trans_o=storage[rd_ptr].
    - ready_o = bufferable_i.
    - Non-bufferable requests stall (ready_o=0) until cnt==0.
  - FULL (cnt==DEPTH):
    - valid_o=1, trans_o=head, ready_o=0.
- Dequeue: cnt>0 && ready_i; rd_ptr advances.
- Enqueue in PARTIAL: valid_i && bufferable_i; wr_ptr advances.
- Enqueue and dequeue in the same cycle: cnt unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. This must work for non-power-of-two DEPTH: explicit wrap at DEPTH-1, no reliance on natural overflow.
- In FULL, an incoming bufferable store is not accepted even if ready_i frees a slot that cycle. ready_o is never combinationally dependent on ready_i when cnt>0.
- Stored transfers are never modified, dropped or reordered. Bus issue order equals upstream acceptance order.
- busy_o = (cnt != 0), registered-derived. empty_o = (cnt==0). full_o = (cnt==DEPTH).
- Reset mid-operation: buffered stores are discarded. Outputs return to their reset values asynchronously.
- Upstream contract (required, not checked): trans_i stable while valid_i && !ready_o.
- Internal properties:
  - cnt never exceeds DEPTH and never underflows.
  - valid_o never deasserts while cnt>0 && !ready_i.

Optional Feature:
- Macro: CV32E40S_WBUF_HWM_EN.
- Defined:
  - Adds output hwm_o [CNT_WIDTH-1:0], a high-water mark.
  - Registered maximum of cnt since reset; updates the cycle after cnt exceeds it; saturates at DEPTH; reset value 0.
- Undefined:
  - Port and register are absent.
  - All other behaviour is identical.

Test Plan:
- Bypass: cnt=0, ready_i=1, non-bufferable load addr 0x100 -> same cycle valid_o=1, trans_o.addr=0x100, ready_o=1; cnt stays 0.
- Buffering: ready_i=0, bufferable stores to 0x200 and 0x204 on consecutive cycles -> both ready_o=1, full_o=1 (DEPTH=2), third store sees ready_o=0. Then ready_i=1 -> bus issues 0x200 then 0x204, empty_o=1 after 2 grants.
- Ordering: buffer holds 1 store at 0x300, non-bufferable load 0x400 presented -> ready_o=0 until the 0x300 grant. Next cycle the load bypasses with trans_o.addr=0x400.
- Simultaneous: cnt=1, ready_i=1, new bufferable store 0x504 -> cnt stays 1, next cycle trans_o.addr=0x504; pointer wrap verified over 5 such cycles.
- Reset mid-operation: cnt=2, assert rst_n=0 asynchronously -> busy_o=0, empty_o=1, valid_o follows valid_i; held stores are never issued.
- HWM (CV32E40S_WBUF_HWM_EN defined): fill to 2, drain to 0 -> hwm_o=2 and stays 2.
